tnn_neuron_serial: RTL and testbench



---
 rtl/tnn_neuron_serial.sv | 215 +++++++++++++++++++++
 tb/tb_tnn_neuron_serial.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tnn_neuron_serial.sv
// tnn_neuron_serial
// Serial ternary-weight neuron. Takes N_IN unsigned features, one per accepted
// input beat, applies a per-feature ternary weight (+1 / -1 / 0), optionally
// drops TRUNC feature LSBs, accumulates a saturating signed sum and compares it
// with a threshold captured on the first accepted feature. The 1-bit class
// decision and the final score are then offered on a valid/ready output.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   w_pos      in   [N_IN]  bit i set: feature i weight +1
//   w_neg      in   [N_IN]  bit i set: feature i weight -1 (both set: weight 0)
//   threshold  in   [ACC_W] signed threshold, captured on first feature
//   clear      in   abort of an evaluation in progress (ignored in DONE)
//   in_valid   in   feature valid
//   in_ready   out  feature can be accepted (decoded from state)
//   in_data    in   [IN_W]  unsigned feature
//   out_valid  out  decision available
//   out_ready  in   consumer takes decision
//   out_bit    out  1 when final acc >= threshold (signed)
//   out_acc    out  [ACC_W] final signed accumulator
//   busy       out  evaluation in progress
module tnn_neuron_serial #(
  parameter int N_IN  = 5,
  parameter int IN_W  = 3,
  parameter int ACC_W = 8,
  parameter int TRUNC = 0,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN-1:0]         w_pos,
  input  logic [N_IN-1:0]         w_neg,
  input  logic signed [ACC_W-1:0] threshold,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    busy
);

  // Elaboration-time parameter sanity.
  if (N_IN < 2) begin : g_bad_n_in
    $error("tnn_neuron_serial: N_IN must be at least 2");
  end
  if (TRUNC < 0 || TRUNC >= IN_W) begin : g_bad_trunc
    $error("tnn_neuron_serial: TRUNC must lie in 0..IN_W-1");
  end
  if ($clog2(N_IN) > CNT_W) begin : g_bad_cnt_w
    $error("tnn_neuron_serial: CNT_W too narrow for N_IN");
  end

  // Internal sum width: wide enough that acc + term can never overflow
  // before saturation is applied.
  localparam int EXT_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 2;
  localparam logic signed [EXT_W-1:0] ACC_MAX =
    {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN =
    {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Clamp a wide signed sum into the ACC_W signed range.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
    if (v > ACC_MAX) begin
      return ACC_MAX[ACC_W-1:0];
    end else if (v < ACC_MIN) begin
      return ACC_MIN[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] thr_q, thr_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_bit_q, out_bit_d;
  logic signed [ACC_W-1:0] out_acc_q, out_acc_d;

  logic                    in_ready_s;
  logic                    in_xfer_s;
  logic                    wp_s;
  logic                    wn_s;
  logic [IN_W-1:0]         f_s;
  logic signed [EXT_W-1:0] f_ext_s;
  logic signed [EXT_W-1:0] term_s;
  logic signed [EXT_W-1:0] acc_ext_s;
  logic signed [ACC_W-1:0] acc_first_s;
  logic signed [ACC_W-1:0] acc_new_s;

  assign in_ready_s = (state_q != S_DONE);
  assign in_xfer_s  = in_valid && in_ready_s;

  // Ternary term for the feature at the current index, plus both candidate
  // accumulator updates (first feature starts from zero).
  always_comb begin
    wp_s      = |(w_pos & (N_IN'(1'b1) << idx_q));
    wn_s      = |(w_neg & (N_IN'(1'b1) << idx_q));
    f_s       = in_data >> TRUNC;
    f_ext_s   = {{(EXT_W-IN_W){1'b0}}, f_s};
    term_s    = {EXT_W{1'b0}};
    if (wp_s && !wn_s) begin
      term_s = f_ext_s;
    end else if (wn_s && !wp_s) begin
      term_s = -f_ext_s;
    end else begin
      term_s = {EXT_W{1'b0}};
    end
    acc_ext_s   = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    acc_first_s = sat_acc(term_s);
    acc_new_s   = sat_acc(acc_ext_s + term_s);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    thr_d       = thr_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_acc_d   = out_acc_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          idx_d = {CNT_W{1'b0}};
          acc_d = {ACC_W{1'b0}};
        end else if (in_xfer_s) begin
          acc_d   = acc_first_s;
          thr_d   = threshold;
          idx_d   = CNT_W'(1'b1);
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (clear) begin
          // Abort: any feature offered this cycle is dropped.
          state_d = S_IDLE;
          idx_d   = {CNT_W{1'b0}};
          acc_d   = {ACC_W{1'b0}};
        end else if (in_xfer_s) begin
          acc_d = acc_new_s;
          if (idx_q == LAST_IDX) begin
            out_acc_d   = acc_new_s;
            out_bit_d   = (acc_new_s >= thr_q);
            out_valid_d = 1'b1;
            idx_d       = {CNT_W{1'b0}};
            state_d     = S_DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1'b1);
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_DONE: begin
        // clear is deliberately ignored here so a decision is never lost.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = {ACC_W{1'b0}};
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        idx_d       = {CNT_W{1'b0}};
        acc_d       = {ACC_W{1'b0}};
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= {CNT_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      thr_q       <= {ACC_W{1'b0}};
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_acc_q   <= {ACC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      thr_q       <= thr_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_acc   = out_acc_q;
  assign busy      = (state_q == S_ACC);

endmodule

// File: tb/tb_tnn_neuron_serial.sv
// Testbench for tnn_neuron_serial: three instances (default, TRUNC=1, ACC_W=4)
// driven by a linear directed sequence; expected decisions are queued when an
// evaluation is driven and compared when the DUT presents its output.
module tb_tnn_neuron_serial;

  logic clk = 1'b0;
  logic rst_n;

  logic [4:0]        w_pos [3];
  logic [4:0]        w_neg [3];
  logic signed [7:0] thr [3];
  logic              clr [3];
  logic              in_valid [3];
  logic [2:0]        in_data [3];
  logic              out_ready [3];
  logic              in_ready [3];
  logic              out_valid [3];
  logic              out_bit [3];
  logic              busy [3];
  logic signed [7:0] acc0;
  logic signed [7:0] acc1;
  logic signed [3:0] acc2;

  typedef struct {
    int dut;
    int acc;
    int b;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tnn_neuron_serial u_def (
    .clk(clk), .rst_n(rst_n), .w_pos(w_pos[0]), .w_neg(w_neg[0]),
    .threshold(thr[0]), .clear(clr[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_bit(out_bit[0]), .out_acc(acc0), .busy(busy[0])
  );

  tnn_neuron_serial #(.TRUNC(1)) u_trunc (
    .clk(clk), .rst_n(rst_n), .w_pos(w_pos[1]), .w_neg(w_neg[1]),
    .threshold(thr[1]), .clear(clr[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_bit(out_bit[1]), .out_acc(acc1), .busy(busy[1])
  );

  tnn_neuron_serial #(.ACC_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .w_pos(w_pos[2]), .w_neg(w_neg[2]),
    .threshold(thr[2][3:0]), .clear(clr[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_bit(out_bit[2]), .out_acc(acc2), .busy(busy[2])
  );

  function automatic logic signed [31:0] acc_of(input int d);
    if (d == 0) return {{24{acc0[7]}}, acc0};
    else if (d == 1) return {{24{acc1[7]}}, acc1};
    else return {{28{acc2[3]}}, acc2};
  endfunction

  function automatic int model_acc(input logic [4:0] wp, input logic [4:0] wn,
                                   input logic [14:0] fv);
    int a = 0;
    for (int i = 0; i < 5; i++) begin
      int f = int'(fv[3*i +: 3]);
      if (wp[i] && !wn[i]) a += f;
      else if (wn[i] && !wp[i]) a -= f;
    end
    return a;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // fv = {f4,f3,f2,f1,f0}; threshold is scrambled after the first beat to show
  // it is only captured once.
  task automatic drive_eval(input int d, input logic [14:0] fv, input logic signed [7:0] t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[d] = 1'b1;
      in_data[d]  = fv[3*i +: 3];
      thr[d]      = (i == 0) ? t : ~t;
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic run_eval(input int d, input logic [4:0] wp, input logic [4:0] wn,
                          input logic [14:0] fv, input logic signed [7:0] t,
                          input int e_acc, input int e_bit);
    exp_t e;
    w_pos[d] = wp;
    w_neg[d] = wn;
    e.dut = d; e.acc = e_acc; e.b = e_bit;
    exp_q.push_back(e);
    drive_eval(d, fv, t);
    check("latency_out_valid", 32'(out_valid[d]), 32'sd1);
  endtask

  task automatic collect(input int d, input int hold);
    exp_t e;
    int   n = 0;
    while (!out_valid[d] && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid[d]), 32'sd1);
    e = exp_q.pop_front();
    check("out_acc", acc_of(d), e.acc);
    check("out_bit", 32'(out_bit[d]), e.b);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready[d]), 32'sd0);
      check("hold_out_valid", 32'(out_valid[d]), 32'sd1);
      check("hold_out_acc", acc_of(d), e.acc);
      check("hold_out_bit", 32'(out_bit[d]), e.b);
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("post_xfer_out_valid", 32'(out_valid[d]), 32'sd0);
    check("post_xfer_in_ready", 32'(in_ready[d]), 32'sd1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      w_pos[d] = 5'd0; w_neg[d] = 5'd0; thr[d] = 8'sd0; clr[d] = 1'b0;
      in_valid[d] = 1'b0; in_data[d] = 3'd0; out_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_in_ready", 32'(in_ready[d]), 32'sd1);
      check("rst_out_valid", 32'(out_valid[d]), 32'sd0);
      check("rst_out_bit", 32'(out_bit[d]), 32'sd0);
      check("rst_out_acc", acc_of(d), 32'sd0);
      check("rst_busy", 32'(busy[d]), 32'sd0);
    end
    rst_n = 1'b1;

    // All +1, 7+7+7 = 21 >= 20.
    run_eval(0, 5'b11111, 5'b00000, {3'd0, 3'd0, 3'd7, 3'd7, 3'd7}, 8'sd20, 21, 1);
    collect(0, 0);
    // Mixed weights: 3+2-4-1-1 = -1 < 0, then 3+2-4-1-0 = 0 >= 0.
    run_eval(0, 5'b00011, 5'b11100, {3'd1, 3'd1, 3'd4, 3'd2, 3'd3}, 8'sd0, -1, 0);
    collect(0, 0);
    run_eval(0, 5'b00011, 5'b11100, {3'd0, 3'd1, 3'd4, 3'd2, 3'd3}, 8'sd0, 0, 1);
    collect(0, 0);

    // TRUNC=1: 7,6,5,1,3 -> 3,3,2,0,1 = 9; feature 0 zero-weighted -> 6.
    run_eval(1, 5'b11111, 5'b00000, {3'd3, 3'd1, 3'd5, 3'd6, 3'd7}, 8'sd9, 9, 1);
    collect(1, 0);
    run_eval(1, 5'b11111, 5'b00001, {3'd3, 3'd1, 3'd5, 3'd6, 3'd7}, 8'sd9, 6, 0);
    collect(1, 0);

    // ACC_W=4: saturation at +7 and at -8, no wrap.
    run_eval(2, 5'b11111, 5'b00000, {5{3'd7}}, 8'sd7, 7, 1);
    collect(2, 0);
    run_eval(2, 5'b00000, 5'b11111, {5{3'd7}}, -8'sd8, -8, 1);
    collect(2, 0);

    // Backpressure: decision held for 10 cycles.
    run_eval(0, 5'b11111, 5'b00000, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 8'sd15, 15, 1);
    check("done_busy", 32'(busy[0]), 32'sd0);
    collect(0, 10);

    // clear after 3 features, with a discarded beat in the clear cycle.
    w_pos[0] = 5'b11111; w_neg[0] = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 3'd7; thr[0] = 8'sd0;
    end
    @(negedge clk);
    check("mid_busy", 32'(busy[0]), 32'sd1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0; in_valid[0] = 1'b0;
    check("clear_busy", 32'(busy[0]), 32'sd0);
    check("clear_in_ready", 32'(in_ready[0]), 32'sd1);
    run_eval(0, 5'b11111, 5'b00000, {5{3'd1}}, 8'sd5, 5, 1);
    collect(0, 0);

    // Synchronous reset after 3 features.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = 3'd6;
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_in_ready", 32'(in_ready[0]), 32'sd1);
    check("mrst_out_valid", 32'(out_valid[0]), 32'sd0);
    check("mrst_out_bit", 32'(out_bit[0]), 32'sd0);
    check("mrst_out_acc", acc_of(0), 32'sd0);
    check("mrst_busy", 32'(busy[0]), 32'sd0);
    run_eval(0, 5'b11111, 5'b00000, {5{3'd2}}, 8'sd11, 10, 0);
    collect(0, 0);

    // clear while DONE must not drop the decision.
    run_eval(0, 5'b11111, 5'b00000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1}, 8'sd2, 1, 0);
    clr[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("clear_in_done_valid", 32'(out_valid[0]), 32'sd1);
    end
    clr[0] = 1'b0;
    collect(0, 0);

    // A few random evaluations against the reference sum.
    for (int k = 0; k < 4; k++) begin
      logic [4:0]        wp;
      logic [4:0]        wn;
      logic [14:0]       fv;
      logic signed [7:0] t;
      int                ea;
      wp = 5'($urandom);
      wn = 5'($urandom);
      fv = 15'($urandom);
      t  = 8'($signed($urandom_range(0, 30)) - 15);
      ea = model_acc(wp, wn, fv);
      run_eval(0, wp, wn, fv, t, ea, (ea >= int'(t)) ? 1 : 0);
      collect(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
